// File: rtl/audio_pkg.sv
// Shared audio-path types: FFT bin indices and squared-magnitude words,
// used by the peak finder and by note_lookup.
package audio_pkg;
    localparam int FFT_SIZE    = 4096;
    localparam int BIN_W       = 13;
    localparam int DATA_W      = 16;
    localparam int MIN_BIN_DEF = 120;
    localparam int MAX_BIN_DEF = 2047;
    localparam logic [31:0] MAG_THRESH_DEF = 32'd4096;

    typedef logic [BIN_W-1:0]  bin_idx_t;
    typedef logic [2*DATA_W:0] mag_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } peak_state_t;
endpackage

// File: rtl/fft_peak_bin_finder_mag_sq.sv
// Two-stage re^2 + im^2 pipeline; bin index, valid and frame-end ride alongside.
module mag_sq_pipe #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 13
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic signed [DATA_W-1:0] i_re,
    input  logic signed [DATA_W-1:0] i_im,
    input  logic                     i_vld,
    input  logic                     i_last,
    input  logic [IDX_W-1:0]         i_idx,
    output logic                     o_s1_vld,
    output logic                     o_vld,
    output logic                     o_last,
    output logic [IDX_W-1:0]         o_idx,
    output logic [2*DATA_W:0]        o_mag
);
    // Squares are never negative, so the signed products can be kept as
    // plain bit patterns; (-2^(W-1))^2 = 2^(2W-2) still fits in 2W bits.
    logic signed [2*DATA_W-1:0] w_re2;
    logic signed [2*DATA_W-1:0] w_im2;
    assign w_re2 = i_re * i_re;
    assign w_im2 = i_im * i_im;

    logic [2*DATA_W-1:0] r_re2, r_im2;
    logic [2*DATA_W:0]   r_mag;
    logic [1:0]          r_vld_pipe;
    logic [1:0]          r_last_pipe;
    logic [IDX_W-1:0]    r_idx1, r_idx2;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_re2       <= '0;
            r_im2       <= '0;
            r_mag       <= '0;
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_idx1      <= '0;
            r_idx2      <= '0;
        end else begin
            r_re2       <= w_re2;
            r_im2       <= w_im2;
            r_mag       <= {1'b0, r_re2} + {1'b0, r_im2};
            r_vld_pipe  <= {r_vld_pipe[0], i_vld};
            r_last_pipe <= {r_last_pipe[0], i_vld & i_last};
            r_idx1      <= i_idx;
            r_idx2      <= r_idx1;
        end
    end

    assign o_s1_vld = r_vld_pipe[0];
    assign o_vld    = r_vld_pipe[1];
    assign o_last   = r_last_pipe[1];
    assign o_idx    = r_idx2;
    assign o_mag    = r_mag;
endmodule

// File: rtl/fft_peak_bin_finder.sv
// Tracks the largest in-band squared magnitude of each FFT frame and strobes
// the winning bin (or 0 for silence) three cycles after the frame-end sample.
module fft_peak_bin_finder
    import audio_pkg::*;
#(
    parameter int          FFT_SIZE   = audio_pkg::FFT_SIZE,
    parameter int          DATA_W     = audio_pkg::DATA_W,
    parameter int          MIN_BIN    = audio_pkg::MIN_BIN_DEF,
    parameter int          MAX_BIN    = audio_pkg::MAX_BIN_DEF,
    parameter logic [31:0] MAG_THRESH = audio_pkg::MAG_THRESH_DEF
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic signed [DATA_W-1:0] fft_re,
    input  logic signed [DATA_W-1:0] fft_im,
    input  logic                     fft_valid,
    input  logic                     fft_last,
    output logic [BIN_W-1:0]         peak_bin,
    output logic [2*DATA_W:0]        peak_mag,
    output logic                     peak_valid,
    output logic                     busy
);
    localparam int MAG_W = 2*DATA_W + 1;
    localparam bin_idx_t L_MIN = bin_idx_t'(MIN_BIN);
    localparam bin_idx_t L_MAX = bin_idx_t'(MAX_BIN);
    localparam bin_idx_t L_END = bin_idx_t'(FFT_SIZE - 1);
    localparam logic [MAG_W-1:0] L_THRESH = MAG_W'(MAG_THRESH);

    // A frame ends on fft_last or at the top bin, so a dropped fft_last
    // cannot make the counter wrap into the next frame.
    bin_idx_t r_bin_cnt;
    logic     w_frame_end;
    assign w_frame_end = fft_last || (r_bin_cnt == L_END);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_bin_cnt <= '0;
        else if (fft_valid)
            r_bin_cnt <= w_frame_end ? '0 : r_bin_cnt + 1'b1;
    end

    logic             w_s1_vld, w_p_vld, w_p_last;
    bin_idx_t         w_p_idx;
    logic [MAG_W-1:0] w_p_mag;

    mag_sq_pipe #(
        .DATA_W (DATA_W),
        .IDX_W  (BIN_W)
    ) u_mag (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_re     (fft_re),
        .i_im     (fft_im),
        .i_vld    (fft_valid),
        .i_last   (w_frame_end),
        .i_idx    (r_bin_cnt),
        .o_s1_vld (w_s1_vld),
        .o_vld    (w_p_vld),
        .o_last   (w_p_last),
        .o_idx    (w_p_idx),
        .o_mag    (w_p_mag)
    );

    peak_state_t      r_state;
    logic [MAG_W-1:0] r_max;
    bin_idx_t         r_idx;
    logic             r_first;
    logic [BIN_W-1:0] r_peak_bin;
    logic [MAG_W-1:0] r_peak_mag;
    logic             r_peak_valid;
    logic             r_busy;

    // The first sample of a frame compares against zero rather than the
    // previous frame's winner, so back-to-back frames never leak state.
    logic [MAG_W-1:0] w_base_max, w_new_max;
    bin_idx_t         w_base_idx, w_new_idx;
    logic             w_in_band, w_take, w_inflight;

    assign w_base_max = r_first ? '0 : r_max;
    assign w_base_idx = r_first ? '0 : r_idx;
    assign w_in_band  = (w_p_idx >= L_MIN) && (w_p_idx <= L_MAX);
    assign w_take     = w_in_band && (w_p_mag > w_base_max);
    assign w_new_max  = w_take ? w_p_mag : w_base_max;
    assign w_new_idx  = w_take ? w_p_idx : w_base_idx;
    assign w_inflight = fft_valid || w_s1_vld || w_p_vld || (r_bin_cnt != '0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state      <= ST_IDLE;
            r_max        <= '0;
            r_idx        <= '0;
            r_first      <= 1'b1;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
            r_peak_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;
            if (w_p_vld) begin
                r_max   <= w_new_max;
                r_idx   <= w_new_idx;
                r_first <= w_p_last;
            end
            if (w_p_vld && w_p_last) begin
                r_peak_valid <= 1'b1;
                r_peak_bin   <= (w_new_max >= L_THRESH) ? w_new_idx : '0;
                r_peak_mag   <= (w_new_max >= L_THRESH) ? w_new_max : '0;
                r_state      <= ST_REPORT;
                r_busy       <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (fft_valid) begin
                            r_state <= ST_SCAN;
                            r_busy  <= 1'b1;
                            r_max   <= '0;
                            r_idx   <= '0;
                        end
                    end
                    ST_SCAN: ;
                    ST_REPORT: begin
                        r_state <= w_inflight ? ST_SCAN : ST_IDLE;
                        r_busy  <= w_inflight;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
    assign peak_valid = r_peak_valid;
    assign busy       = r_busy;
endmodule

// File: tb/tb_fft_peak_bin_finder.sv
// Scoreboard bench: frames are built in arrays, a reference model derives each
// frame's expected peak, and a monitor checks every peak_valid strobe.
module tb_fft_peak_bin_finder;
    localparam int NBINS = 4096;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic signed [15:0] fft_re, fft_im;
    logic               fft_valid, fft_last;
    logic [12:0]        peak_bin;
    logic [32:0]        peak_mag;
    logic               peak_valid, busy;

    fft_peak_bin_finder dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .fft_re     (fft_re),
        .fft_im     (fft_im),
        .fft_valid  (fft_valid),
        .fft_last   (fft_last),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int     bin;
        longint mag;
        int     at;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int fre[NBINS];
    int fim[NBINS];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Peak of a frame straight from the rules: in-band, strictly larger wins,
    // silence below threshold reports bin 0 / magnitude 0.
    function automatic void model(input int n, output int b, output longint m);
        longint best = 0;
        int     bi   = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= 120 && i <= 2047) begin
                longint v;
                v = longint'(fre[i]) * fre[i] + longint'(fim[i]) * fim[i];
                if (v > best) begin
                    best = v;
                    bi   = i;
                end
            end
        end
        if (best >= 4096) begin
            b = bi;
            m = best;
        end else begin
            b = 0;
            m = 0;
        end
    endfunction

    task automatic clear_frame(input int amp);
        for (int i = 0; i < NBINS; i++) begin
            fre[i] = (amp > 0) ? int'($urandom_range(2*amp)) - amp : 0;
            fim[i] = (amp > 0) ? int'($urandom_range(2*amp)) - amp : 0;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk_in);
            fft_valid = 1'b0;
            fft_last  = 1'b0;
        end
    endtask

    // Drives one frame; leaves the last sample on the bus so the next call can
    // follow back-to-back. abort_at >= 0 pulses reset instead of that bin.
    task automatic send_frame(input int n, input bit with_last, input int gap, input int abort_at);
        int     b;
        longint m;
        model(n, b, m);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                @(negedge clk_in);
                fft_valid = 1'b0;
                fft_last  = 1'b0;
                rst_in    = 1'b1;
                repeat (2) @(negedge clk_in);
                rst_in = 1'b0;
                chk("abort_peak_valid", peak_valid, 0);
                chk("abort_peak_bin", peak_bin, 0);
                chk("abort_peak_mag", peak_mag, 0);
                chk("abort_busy", busy, 0);
                return;
            end
            if (i > 0) begin
                while (gap > 0 && int'($urandom_range(99)) < gap) begin
                    @(negedge clk_in);
                    fft_valid = 1'b0;
                    fft_last  = 1'b0;
                end
            end
            @(negedge clk_in);
            if (i == n/2) chk("busy_mid_frame", busy, 1);
            fft_valid = 1'b1;
            fft_re    = 16'(fre[i]);
            fft_im    = 16'(fim[i]);
            fft_last  = with_last && (i == n-1);
            if (i == n-1) sb.push_back('{b, m, cyc + 3});
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_in);
            if (peak_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("peak_bin", peak_bin, e.bin);
                    chk("peak_mag", peak_mag, e.mag);
                    chk("peak_latency", cyc, e.at);
                end
            end
        end
    end

    initial begin
        rst_in    = 1'b1;
        fft_valid = 1'b0;
        fft_last  = 1'b0;
        fft_re    = '0;
        fft_im    = '0;
        repeat (3) @(negedge clk_in);
        chk("rst_peak_bin", peak_bin, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_busy", busy, 0);
        rst_in = 1'b0;

        clear_frame(0); fre[300] = 1000;
        send_frame(1024, 1, 0, -1); idle(4);
        chk("busy_after_frame", busy, 0);

        clear_frame(0); fre[50] = 30000; fim[50] = 30000; fre[500] = 100;
        send_frame(600, 1, 0, -1); idle(4);

        clear_frame(0); fre[400] = 10; fim[400] = 10;
        send_frame(512, 1, 0, -1); idle(4);

        clear_frame(0); fre[200] = -32768; fre[250] = -32768;
        send_frame(300, 1, 0, -1); idle(4);

        clear_frame(20); fre[1000] = 1500; fre[2047] = 2000;
        send_frame(2048, 1, 0, -1); idle(4);

        // Back-to-back frames with gaps, including one without fft_last.
        clear_frame(20); fre[420] = 5000;
        send_frame(800, 1, 30, -1);
        clear_frame(20); fim[131] = -4000;
        send_frame(700, 1, 30, -1);
        clear_frame(15); fre[1500] = 3000;
        send_frame(NBINS, 0, 10, -1);
        clear_frame(15); fre[150] = 900;
        send_frame(200, 1, 0, -1); idle(4);

        clear_frame(0); fre[600] = 7000;
        send_frame(2000, 1, 0, 1000); idle(4);
        clear_frame(10); fre[777] = 2500;
        send_frame(1500, 1, 0, -1); idle(4);

        for (int k = 0; k < 6; k++) begin
            clear_frame(60);
            repeat (3) fre[$urandom_range(NBINS-1)] = int'($urandom_range(4000)) - 2000;
            send_frame(int'($urandom_range(3000, 130)), 1, int'($urandom_range(40)), -1);
            if ($urandom_range(1) == 1) idle(2);
        end
        idle(1);

        begin
            int t = 0;
            while (sb.size() > 0 && t < 50) begin
                @(negedge clk_in);
                t++;
            end
            if (sb.size() > 0) chk("strobe_timeout", sb.size(), 0);
        end
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
